// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter stage.
package pc_pkg;

  localparam int unsigned PC_W          = 32;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_pending_reg.sv
// Holds one redirect target that arrived during a stall, until the stall releases.
module pc_pending_reg
  import pc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            capture,
  input  logic            clear,
  input  logic [PC_W-1:0] target_in,
  output logic [PC_W-1:0] target,
  output logic            valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      target <= '0;
      valid  <= 1'b0;
    end else if (capture) begin
      target <= target_in;
      valid  <= 1'b1;
    end else if (clear) begin
      target <= '0;
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/program_counter.sv
// Fetch-address register with stall/redirect handling and a buffered redirect.
// Optional macro BRANCH_DELAY_SLOT_EN: delay-slot mode, Flush tied low.
module program_counter
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [PC_W-1:0] PCPlus4,
  input  logic [PC_W-1:0] BranchTarget,
  input  logic [PC_W-1:0] JumpTarget,
  input  logic            BranchTaken,
  input  logic            Jump,
  input  logic            Stall,
  output logic [PC_W-1:0] PC,
  output logic            PCValid,
  output logic            Flush,
  output logic [PC_W-1:0] FetchCount
);

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit FLUSH_EN = 1'b0;
`else
  localparam bit FLUSH_EN = 1'b1;
`endif

  pc_state_e       state, state_next;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] target;
  logic            redirect;
  logic            advance;
  logic            capture;
  logic            clear;
  logic            flush_req;
  logic [PC_W-1:0] pend_target;
  logic            pend_valid;

  pc_pending_reg u_pending (
    .clk       (Clk),
    .rst       (Rst),
    .capture   (capture),
    .clear     (clear),
    .target_in (target),
    .target    (pend_target),
    .valid     (pend_valid)
  );

  always_comb begin
    redirect   = Jump | BranchTaken;
    target     = (Jump ? JumpTarget : BranchTarget) & PC_ALIGN_MASK;
    state_next = state;
    pc_next    = PC;
    advance    = 1'b0;
    capture    = 1'b0;
    clear      = 1'b0;
    flush_req  = 1'b0;
    unique case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (!Stall) begin
          advance   = 1'b1;
          flush_req = redirect;
          pc_next   = redirect ? target : (PCPlus4 & PC_ALIGN_MASK);
        end else if (redirect) begin
          capture    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        // Redirects seen here are younger, wrong-path requests; only the buffered one lands.
        if (!Stall) begin
          advance    = 1'b1;
          flush_req  = 1'b1;
          clear      = 1'b1;
          state_next = RUN;
          if (pend_valid) pc_next = pend_target;
        end
      end
      default: state_next = BOOT;
    endcase
    if (Rst) flush_req = 1'b0;
  end

  assign Flush = FLUSH_EN & flush_req;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= BOOT;
      PC         <= RESET_PC;
      PCValid    <= 1'b0;
      FetchCount <= '0;
    end else begin
      state <= state_next;
      PC    <= pc_next;
      if (state == BOOT) PCValid <= 1'b1;
      if (advance) FetchCount <= FetchCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: driver pushes expected results, monitor compares.
module tb_program_counter;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] PCPlus4 = '0;
  logic [31:0] BranchTarget = '0;
  logic [31:0] JumpTarget = '0;
  logic        BranchTaken = 1'b0;
  logic        Jump = 1'b0;
  logic        Stall = 1'b0;
  logic [31:0] PC;
  logic        PCValid;
  logic        Flush;
  logic [31:0] FetchCount;

  program_counter #(.RESET_PC(RST_PC)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .PCPlus4      (PCPlus4),
    .BranchTarget (BranchTarget),
    .JumpTarget   (JumpTarget),
    .BranchTaken  (BranchTaken),
    .Jump         (Jump),
    .Stall        (Stall),
    .PC           (PC),
    .PCValid      (PCValid),
    .Flush        (Flush),
    .FetchCount   (FetchCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        flush;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] count;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   driver_done = 1'b0;

  // Reference model: plain variables, pending redirect modelled as a queue of at most one entry.
  logic [31:0] m_pc = RST_PC;
  logic        m_valid = 1'b0;
  logic [31:0] m_count = '0;
  bit          m_boot = 1'b1;
  logic [31:0] pend_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rst, input bit stall, input bit jmp, input bit bt,
                       input logic [31:0] jt, input logic [31:0] btg);
    exp_t        e;
    bit          redir;
    logic [31:0] tgt;
    @(negedge Clk);
    Rst          = rst;
    Stall        = stall;
    Jump         = jmp;
    BranchTaken  = bt;
    JumpTarget   = jt;
    BranchTarget = btg;
    PCPlus4      = m_pc + 32'd4;
    redir = jmp | bt;
    tgt   = (jmp ? jt : btg) & 32'hFFFF_FFFC;
`ifdef BRANCH_DELAY_SLOT_EN
    e.flush = 1'b0;
`else
    e.flush = !rst && !m_boot && !stall && (redir || pend_q.size() > 0);
`endif
    if (rst) begin
      m_pc = RST_PC; m_valid = 1'b0; m_count = '0; m_boot = 1'b1;
      pend_q.delete();
    end else if (m_boot) begin
      m_boot = 1'b0; m_valid = 1'b1;
    end else if (!stall) begin
      if (pend_q.size() > 0) m_pc = pend_q[0];
      else if (redir)        m_pc = tgt;
      else                   m_pc = m_pc + 32'd4;
      pend_q.delete();
      m_count = m_count + 32'd1;
    end else if (redir && pend_q.size() == 0) begin
      pend_q.push_back(tgt);
    end
    e.pc = m_pc; e.valid = m_valid; e.count = m_count;
    exp_q.push_back(e);
  endtask

  task automatic free_cycles(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  // Monitor: Flush sampled mid-cycle before the edge, registered outputs just after it.
  initial begin
    exp_t e;
    logic f;
    forever begin
      @(negedge Clk);
      #2 f = Flush;
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("flush", {31'b0, f}, {31'b0, e.flush});
        check("pc", PC, e.pc);
        check("pc_valid", {31'b0, PCValid}, {31'b0, e.valid});
        check("fetch_count", FetchCount, e.count);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1, 0, 0, 0, 32'h0, 32'h0);
    free_cycles(4);
    drive(0, 0, 0, 1, 32'h0, 32'h203);
    free_cycles(2);
    drive(0, 1, 1, 0, 32'h400, 32'h0);
    drive(0, 1, 0, 1, 32'h0, 32'h500);
    drive(0, 1, 0, 0, 32'h0, 32'h0);
    free_cycles(2);
    drive(0, 0, 1, 1, 32'h600, 32'h700);
    free_cycles(1);
    drive(0, 1, 0, 1, 32'h0, 32'h800);
    drive(0, 1, 0, 0, 32'h0, 32'h0);
    drive(1, 1, 0, 0, 32'h0, 32'h0);
    free_cycles(4);
    drive(0, 0, 1, 0, 32'hFFFF_FFFF, 32'h0);
    free_cycles(2);
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 35,
            $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 15,
            $urandom, $urandom);
    end
    free_cycles(3);
    repeat (3) @(posedge Clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0", exp_q.size());
    end
    driver_done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
